// File: rtl/sync_pkg.sv
// Shared types and constants for the frame-sync flywheel.
// Lock states, status word layout and period width.
package sync_pkg;

   localparam int PER_W = 19;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCK    = 2'd2,
      HOLD    = 2'd3
   } state_t;

   localparam int ST_STATE_LSB = 30;
   localparam int ST_CFG_BIT   = 29;
   localparam int ST_MISS_LSB  = 16;
   localparam int ST_HIT_LSB   = 8;
   localparam int ST_PERR_LSB  = 0;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sync_win_cnt.sv
// Frame-phase flywheel counter with acceptance window
// and early/late phase error of the current sample.
module sync_win_cnt
   import sync_pkg::*;
#(
   parameter int pWIN = 32
) (
   input  logic             iclk,
   input  logic             ireset,
   input  logic             i_run,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [PER_W-1:0] i_period,
   output logic             o_in_win,
   output logic             o_win_close,
   output logic             o_early,
   output logic             o_zero,
   output logic [15:0]      o_phase
);

   localparam logic [PER_W:0] L_WIN   = (PER_W+1)'(pWIN);
   localparam logic [PER_W:0] L_CLOSE = (PER_W+1)'(pWIN + 1);
   localparam logic [PER_W:0] L_ONE   = (PER_W+1)'(1);

   logic [PER_W-1:0] r_ph;
   logic [PER_W:0]   w_ph;
   logic [PER_W:0]   w_per;
   logic [PER_W:0]   w_early_lo;
   logic             w_late;

   assign w_ph       = {1'b0, r_ph};
   assign w_per      = {1'b0, i_period};
   assign w_early_lo = w_per - L_WIN;

   // ph never exceeds P-1, so only the lower edge of the early window matters
   assign o_early     = (w_ph >= w_early_lo);
   assign w_late      = (w_ph <= L_WIN);
   assign o_in_win    = o_early | w_late;
   assign o_win_close = (w_ph == L_CLOSE);
   assign o_zero      = (r_ph == '0);
   assign o_phase     = o_early ? (r_ph[15:0] - i_period[15:0])
                                : r_ph[15:0];

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         r_ph <= '0;
      end else if (i_clr) begin
         r_ph <= '0;
      end else if (i_load) begin
         r_ph <= PER_W'(1);
      end else if (i_run) begin
         r_ph <= (w_ph == w_per - L_ONE) ? '0 : r_ph + 1'b1;
      end
   end

endmodule

// File: rtl/sync_flywheel.sv
// Frame-sync lock FSM: SEARCH/ACQUIRE/LOCK/HOLD around a
// phase flywheel, giving a periodic frame strobe and status.
module sync_flywheel
   import sync_pkg::*;
#(
   parameter int pWIN      = 32,
   parameter int pLOCK_CNT = 4,
   parameter int pMISS_MAX = 8
) (
   input  logic             iclk,
   input  logic             ireset,
   input  logic             iena,
   input  logic             isop,
   input  logic             ivrf_val,
   input  logic [PER_W-1:0] time_sop,
   output logic             ofrm_sop,
   output logic             olock,
   output logic [1:0]       ostate,
   output logic [15:0]      ophase_err,
   output logic [7:0]       omiss_cnt,
   output logic             ocfg_err,
   output logic [31:0]      ostat_data
);

   localparam logic [7:0]       L_LOCK = 8'(pLOCK_CNT);
   localparam logic [7:0]       L_MISS = 8'(pMISS_MAX);
   localparam logic [PER_W-1:0] L_MINP = PER_W'(2*pWIN + 2);

   state_t           r_state;
   logic [PER_W-1:0] r_period;
   logic [7:0]       r_hit_cnt;
   logic [7:0]       r_miss_cnt;
   logic             r_hit_flag;
   logic             r_frm_sop;
   logic             r_lock;
   logic             r_cfg_err;
   logic [15:0]      r_phase_err;
   logic [31:0]      r_stat;

   logic        w_in_win;
   logic        w_win_close;
   logic        w_early;
   logic        w_zero;
   logic [15:0] w_phase;
   logic        w_active;
   logic        w_acq;
   logic        w_hit;
   logic        w_hit_ok;
   logic        w_miss;
   logic        w_tout;
   logic        w_drop;
   logic        w_load;
   logic [7:0]  w_hit_inc;
   logic [7:0]  w_acq_inc;
   logic [31:0] w_stat;

   assign w_active = (r_state != SEARCH);
   assign w_acq    = iena & ~w_active & isop & ~r_cfg_err;
   assign w_hit    = w_active & isop & w_in_win & ~r_hit_flag;
   assign w_miss   = w_active & w_win_close & ~r_hit_flag;
   assign w_tout   = (r_state == HOLD) & (r_miss_cnt == L_MISS);
   // disable, hold timeout and acquire miss all win over a same-cycle SOP
   assign w_drop   = ~iena | w_tout | ((r_state == ACQUIRE) & w_miss);
   assign w_hit_ok = w_hit & ~w_drop;
   assign w_load   = ~w_drop & (w_acq | w_hit);

   assign w_hit_inc = sat_inc8(r_hit_cnt);
   assign w_acq_inc = (w_hit_inc > L_LOCK) ? L_LOCK : w_hit_inc;

   sync_win_cnt #(
      .pWIN(pWIN)
   ) u_win (
      .iclk       (iclk),
      .ireset     (ireset),
      .i_run      (w_active),
      .i_clr      (w_drop),
      .i_load     (w_load),
      .i_period   (r_period),
      .o_in_win   (w_in_win),
      .o_win_close(w_win_close),
      .o_early    (w_early),
      .o_zero     (w_zero),
      .o_phase    (w_phase)
   );

   always_comb begin
      w_stat = '0;
      w_stat[ST_CFG_BIT] = r_cfg_err;
      if (iena) begin
         w_stat[ST_STATE_LSB +: 2] = r_state;
         w_stat[ST_MISS_LSB  +: 8] = r_miss_cnt;
         w_stat[ST_HIT_LSB   +: 8] = r_hit_cnt;
         w_stat[ST_PERR_LSB  +: 8] = r_phase_err[7:0];
      end
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         r_state     <= SEARCH;
         r_period    <= '0;
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
         r_hit_flag  <= 1'b0;
         r_frm_sop   <= 1'b0;
         r_lock      <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_phase_err <= '0;
         r_stat      <= '0;
      end else begin
         r_cfg_err <= (time_sop < L_MINP);
         r_stat    <= w_stat;
         r_frm_sop <= ~w_drop & (w_acq | (w_active & w_zero)
                                 | (w_hit_ok & w_early));
         if (w_hit_ok) begin
            r_hit_flag  <= 1'b1;
            r_phase_err <= w_phase;
         end else if (w_win_close) begin
            r_hit_flag <= 1'b0;
         end
         if (w_drop) begin
            r_state    <= SEARCH;
            r_lock     <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_hit_flag <= 1'b0;
            if (!iena) r_phase_err <= '0;
         end else begin
            unique case (r_state)
               SEARCH: begin
                  if (w_acq) begin
                     r_state    <= ACQUIRE;
                     r_hit_cnt  <= 8'd1;
                     r_hit_flag <= 1'b1;
                     r_period   <= time_sop;
                  end
               end
               ACQUIRE: begin
                  if (w_hit) begin
                     r_hit_cnt <= w_acq_inc;
                     if ((w_acq_inc == L_LOCK) && ivrf_val) begin
                        r_state    <= LOCK;
                        r_lock     <= 1'b1;
                        r_miss_cnt <= '0;
                     end
                  end
               end
               LOCK: begin
                  if (w_hit) begin
                     r_hit_cnt  <= w_hit_inc;
                     r_miss_cnt <= '0;
                  end else if (w_miss) begin
                     r_state    <= HOLD;
                     r_miss_cnt <= 8'd1;
                  end
               end
               HOLD: begin
                  if (w_hit) begin
                     r_state    <= LOCK;
                     r_hit_cnt  <= w_hit_inc;
                     r_miss_cnt <= '0;
                  end else if (w_miss) begin
                     r_miss_cnt <= sat_inc8(r_miss_cnt);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign ofrm_sop   = r_frm_sop;
   assign olock      = r_lock;
   assign ostate     = r_state;
   assign ophase_err = r_phase_err;
   assign omiss_cnt  = r_miss_cnt;
   assign ocfg_err   = r_cfg_err;
   assign ostat_data = r_stat;

endmodule

// File: tb/tb_sync_flywheel.sv
// Bench for sync_flywheel: config table, scripted lock scenarios,
// randomized SOP streams against an absolute-time reference model.
module tb_sync_flywheel;

   localparam int W     = 32;
   localparam int NLOCK = 4;
   localparam int NMISS = 8;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena   = 1'b0;
   logic        sop   = 1'b0;
   logic        vrf   = 1'b0;
   logic [18:0] tsop  = 19'd1000;

   logic        frm;
   logic        lock;
   logic [1:0]  st;
   logic [15:0] perr;
   logic [7:0]  miss;
   logic        cfg;
   logic [31:0] stat;

   int n_tests = 0;
   int n_fail  = 0;

   sync_flywheel #(
      .pWIN(W), .pLOCK_CNT(NLOCK), .pMISS_MAX(NMISS)
   ) dut (
      .iclk(clk), .ireset(rst_n), .iena(ena), .isop(sop),
      .ivrf_val(vrf), .time_sop(tsop), .ofrm_sop(frm),
      .olock(lock), .ostate(st), .ophase_err(perr),
      .omiss_cnt(miss), .ocfg_err(cfg), .ostat_data(stat)
   );

   always #5 clk = ~clk;

   // Model: phase is (now - anchor) mod P, anchor = cycle of last phase 0
   int          m_cyc    = 0;
   int          m_anchor = 0;
   int          m_p      = 1;
   int          m_st     = 0;
   int          m_hit    = 0;
   int          m_miss   = 0;
   int          m_perr   = 0;
   bit          m_flag   = 1'b0;
   bit          m_frm    = 1'b0;
   bit          m_cfg    = 1'b0;
   logic [31:0] m_stat   = '0;
   bit          chk_en   = 1'b0;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_step();
      int ph;
      bit early;
      bit late;
      bit close;
      bit hit;
      bit ncfg;
      logic [31:0] nstat;
      ph = (m_st != 0) ? (m_cyc - m_anchor) % m_p : 0;
      nstat = ena ? {m_st[1:0], m_cfg, 5'd0, m_miss[7:0], m_hit[7:0],
                     m_perr[7:0]} : {2'b00, m_cfg, 29'd0};
      ncfg = (int'(tsop) < 2*W + 2);
      m_frm = 1'b0;
      if (!ena) begin
         m_st = 0; m_hit = 0; m_miss = 0; m_flag = 0; m_perr = 0;
      end else if (m_st == 0) begin
         if (sop && !m_cfg) begin
            m_st = 1; m_hit = 1; m_flag = 1; m_p = int'(tsop);
            m_anchor = m_cyc; m_frm = 1;
         end
      end else if (m_st == 3 && m_miss == NMISS) begin
         m_st = 0; m_hit = 0; m_miss = 0; m_flag = 0;
      end else begin
         early = (ph >= m_p - W);
         late  = (ph <= W);
         close = (ph == W + 1);
         hit   = sop && (early || late) && !m_flag;
         if (ph == 0 || (hit && early)) m_frm = 1;
         if (hit) begin
            m_flag = 1;
            m_perr = early ? ph - m_p : ph;
            m_anchor = m_cyc;
            if (m_st == 1) begin
               m_hit = imin(m_hit + 1, NLOCK);
               if (m_hit == NLOCK && vrf) begin
                  m_st = 2; m_miss = 0;
               end
            end else begin
               m_hit = imin(m_hit + 1, 255); m_st = 2; m_miss = 0;
            end
         end else if (close) begin
            if (!m_flag) begin
               if (m_st == 1) begin
                  m_st = 0; m_hit = 0; m_miss = 0;
               end else if (m_st == 2) begin
                  m_st = 3; m_miss = 1;
               end else begin
                  m_miss = imin(m_miss + 1, 255);
               end
            end
            m_flag = 0;
         end
      end
      m_stat = nstat;
      m_cfg  = ncfg;
      m_cyc++;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc = 0; m_anchor = 0; m_p = 1; m_st = 0; m_hit = 0;
         m_miss = 0; m_perr = 0; m_flag = 0; m_frm = 0; m_cfg = 0;
         m_stat = '0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_tests++;
         if ({frm, lock, st, perr, miss, cfg, stat} !==
             {m_frm, (m_st >= 2), m_st[1:0], m_perr[15:0], m_miss[7:0],
              m_cfg, m_stat}) begin
            n_fail++;
            $display("FAIL model t=%0t got frm=%b lk=%b st=%0d pe=%0d ms=%0d cfg=%b stat=%h want frm=%b st=%0d pe=%0d ms=%0d cfg=%b stat=%h",
                     $time, frm, lock, st, $signed(perr), miss, cfg, stat,
                     m_frm, m_st, m_perr, m_miss, m_cfg, m_stat);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_sop();
      sop = 1'b1;
      @(negedge clk);
      sop = 1'b0;
   endtask

   task automatic count_frm(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         cnt += int'(frm);
      end
   endtask

   typedef struct {
      logic [18:0] p;
      logic        e_cfg;
      logic [1:0]  e_st;
   } cfg_vec_t;

   cfg_vec_t cv[7];

   initial begin
      int cnt;
      int sp;
      int r;
      cv[0] = '{19'd60,     1'b1, 2'd0};
      cv[1] = '{19'd0,      1'b1, 2'd0};
      cv[2] = '{19'd65,     1'b1, 2'd0};
      cv[3] = '{19'd66,     1'b0, 2'd1};
      cv[4] = '{19'd67,     1'b0, 2'd1};
      cv[5] = '{19'd1000,   1'b0, 2'd1};
      cv[6] = '{19'd524287, 1'b0, 2'd1};

      gap(3);
      chk("reset_outs", {frm, lock, st, perr, miss, cfg, stat}, '0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      ena    = 1'b1;

      for (int i = 0; i < 7; i++) begin
         tsop = cv[i].p;
         @(negedge clk);
         send_sop();
         chk("cfg_err", cfg, cv[i].e_cfg);
         chk("cfg_state", st, cv[i].e_st);
         ena = 1'b0;
         @(negedge clk);
         ena = 1'b1;
         @(negedge clk);
      end

      tsop = 19'd1000;
      vrf  = 1'b1;
      @(negedge clk);
      send_sop();
      chk("acq_state", st, 2'd1);
      chk("acq_frm", frm, 1'b1);
      for (int k = 2; k <= 4; k++) begin
         gap(999);
         send_sop();
      end
      chk("lock_state", st, 2'd2);
      chk("lock_olock", lock, 1'b1);
      chk("lock_perr", perr, 16'd0);
      count_frm(1000, cnt);
      chk("lock_period_pulses", cnt, 1);

      gap(989);
      send_sop();
      chk("early_perr", perr, 16'hFFF6);
      chk("early_frm", frm, 1'b1);
      chk("early_state", st, 2'd2);
      count_frm(999, cnt);
      chk("early_no_extra", cnt, 0);
      count_frm(1, cnt);
      chk("early_realigned", cnt, 1);

      gap(19);
      send_sop();
      chk("late_perr", perr, 16'd20);
      chk("late_no_pulse", frm, 1'b0);
      chk("late_state", st, 2'd2);
      count_frm(999, cnt);
      chk("late_no_extra", cnt, 0);
      count_frm(1, cnt);
      chk("late_realigned", cnt, 1);

      gap(33);
      chk("hold_state", st, 2'd3);
      chk("hold_miss1", miss, 8'd1);
      chk("hold_olock", lock, 1'b1);
      for (int k = 2; k <= NMISS; k++) begin
         count_frm(1000, cnt);
         chk("hold_pulse", cnt, 1);
         chk("hold_miss", miss, 8'(k));
         chk("hold_stay", st, 2'd3);
      end
      gap(1);
      chk("tout_state", st, 2'd0);
      chk("tout_miss", miss, 8'd0);
      chk("tout_olock", lock, 1'b0);
      count_frm(2000, cnt);
      chk("tout_silent", cnt, 0);

      vrf = 1'b0;
      send_sop();
      for (int k = 2; k <= 6; k++) begin
         gap(999);
         send_sop();
      end
      chk("novrf_state", st, 2'd1);
      gap(1);
      chk("novrf_hitcnt", stat[15:8], 8'd4);
      vrf = 1'b1;
      gap(993);
      send_sop();
      chk("vrf_lock", st, 2'd2);
      chk("vrf_perr", perr, 16'hFFFB);

      gap(500);
      ena = 1'b0;
      @(negedge clk);
      chk("dis_outs", {frm, lock, st, perr, miss, stat}, '0);
      ena = 1'b1;
      @(negedge clk);

      tsop = 19'd100;
      send_sop();
      for (int k = 2; k <= 4; k++) begin
         gap(99);
         send_sop();
      end
      chk("rst_pre_lock", st, 2'd2);
      gap(37);
      #2 rst_n = 1'b0;
      #1 chk("async_rst", {frm, lock, st, perr, miss, cfg, stat}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int f = 0; f < 200; f++) begin
         r = int'($urandom_range(0, 19));
         if (r == 0) begin
            ena = 1'b0;
            gap(2);
            ena = 1'b1;
         end
         if (r == 1) tsop = 19'($urandom_range(70, 200));
         vrf = ($urandom_range(0, 3) != 0);
         sp = int'(tsop) + int'($urandom_range(0, 80)) - 40;
         if (r >= 2 && r <= 4) sp = sp + int'(tsop);
         gap(sp - 1);
         send_sop();
         if (r == 5) begin
            gap(2);
            send_sop();
         end
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
